// File: rtl/f_pc_fd_reg_pkg.sv
// Shared constants for the fetch PC / F-D pipeline register: exception codes
// and default reset, handler and instruction-memory window addresses.
package f_pc_fd_reg_pkg;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_TOP_DEF   = 32'h0000_6FFC;

endpackage

// File: rtl/f_pc_fd_reg_adel_check.sv
// f_adel_check: combinational fetch-address checker. Flags a misaligned word
// address or one outside the instruction memory window (unsigned compare).
module f_adel_check
  import f_pc_fd_reg_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
  parameter logic [31:0] IMEM_TOP  = IMEM_TOP_DEF
) (
  input  logic [31:0] i_pc,
  output logic        o_adel
);

  // Alignment and range test on the current fetch address
  always_comb begin
    o_adel = 1'b0;
    if ((i_pc[1:0] != 2'b00) || (i_pc < IMEM_BASE) || (i_pc > IMEM_TOP)) begin
      o_adel = 1'b1;
    end else begin
      o_adel = 1'b0;
    end
  end

endmodule

// File: rtl/f_pc_fd_reg.sv
// f_pc_fd_reg: fetch PC register and F/D pipeline register with stall,
// exception flush and eret flush. FETCH_ADEL_EN enables fetch AdEL detection.
module f_pc_fd_reg
  import f_pc_fd_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
`ifdef FETCH_ADEL_EN
  ,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter logic [31:0] IMEM_TOP   = IMEM_TOP_DEF
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_PC,
  input  logic        stall,
  input  logic        req,
  input  logic        D_eret,
  input  logic        D_is_jump,
  input  logic [31:0] F_Instr_in,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD
);

  logic [31:0] r_f_pc;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_instr;
  logic [4:0]  r_d_exc;
  logic        r_d_bd;

  logic [31:0] w_instr;
  logic [4:0]  w_exc_code;

`ifdef FETCH_ADEL_EN
  logic w_adel;

  f_adel_check #(
    .IMEM_BASE (IMEM_BASE),
    .IMEM_TOP  (IMEM_TOP)
  ) u_adel_check (
    .i_pc   (r_f_pc),
    .o_adel (w_adel)
  );

  // A faulting fetch enters D as a zero word tagged with AdEL
  always_comb begin
    w_instr    = F_Instr_in;
    w_exc_code = EXC_NONE;
    if (w_adel) begin
      w_instr    = 32'h0000_0000;
      w_exc_code = EXC_ADEL;
    end else begin
      w_instr    = F_Instr_in;
      w_exc_code = EXC_NONE;
    end
  end
`else
  assign w_instr    = F_Instr_in;
  assign w_exc_code = EXC_NONE;
`endif

  // PC and F/D state; req outranks stall so a taken exception is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_pc    <= RESET_PC;
      r_d_pc    <= RESET_PC;
      r_d_instr <= 32'h0000_0000;
      r_d_exc   <= EXC_NONE;
      r_d_bd    <= 1'b0;
    end else if (req) begin
      r_f_pc    <= next_PC;
      r_d_pc    <= HANDLER_PC;
      r_d_instr <= 32'h0000_0000;
      r_d_exc   <= EXC_NONE;
      r_d_bd    <= 1'b0;
    end else if (stall) begin
      r_f_pc    <= r_f_pc;
      r_d_pc    <= r_d_pc;
      r_d_instr <= r_d_instr;
      r_d_exc   <= r_d_exc;
      r_d_bd    <= r_d_bd;
    end else if (D_eret) begin
      // The eret delay slot is squashed but keeps its PC for tracing
      r_f_pc    <= next_PC;
      r_d_pc    <= r_f_pc;
      r_d_instr <= 32'h0000_0000;
      r_d_exc   <= EXC_NONE;
      r_d_bd    <= 1'b0;
    end else begin
      r_f_pc    <= next_PC;
      r_d_pc    <= r_f_pc;
      r_d_instr <= w_instr;
      r_d_exc   <= w_exc_code;
      r_d_bd    <= D_is_jump;
    end
  end

  assign F_PC      = r_f_pc;
  assign D_PC      = r_d_pc;
  assign D_Instr   = r_d_instr;
  assign D_ExcCode = r_d_exc;
  assign D_BD      = r_d_bd;

endmodule

// File: tb/tb_f_pc_fd_reg.sv
// Self-checking bench for f_pc_fd_reg: directed scenarios plus random traffic
// compared every cycle against a behavioural fetch-pipeline model.
module tb_f_pc_fd_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_PC;
  logic        stall, req, D_eret, D_is_jump;
  logic [31:0] F_Instr_in;
  logic [31:0] F_PC, D_PC, D_Instr;
  logic [4:0]  D_ExcCode;
  logic        D_BD;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_f_pc, m_d_pc, m_d_instr;
  logic [4:0]  m_d_exc;
  logic        m_d_bd;

  f_pc_fd_reg dut (
    .clk(clk), .rst_n(rst_n), .next_PC(next_PC), .stall(stall), .req(req),
    .D_eret(D_eret), .D_is_jump(D_is_jump), .F_Instr_in(F_Instr_in),
    .F_PC(F_PC), .D_PC(D_PC), .D_Instr(D_Instr), .D_ExcCode(D_ExcCode), .D_BD(D_BD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign F_Instr_in = im_word(F_PC);

  function automatic bit fetch_fault(input logic [31:0] pc);
`ifdef FETCH_ADEL_EN
    return (pc % 32'd4 != 32'd0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_f_pc = 32'h0000_3000; m_d_pc = 32'h0000_3000;
    m_d_instr = 32'h0; m_d_exc = 5'd0; m_d_bd = 1'b0;
  endtask

  // One clock: apply inputs, advance model by the pipeline rules, settle past the edge
  task automatic tick(input logic [31:0] np, input bit st, input bit rq,
                      input bit er, input bit jp);
    logic [31:0] n_f, n_dpc, n_di;
    logic [4:0]  n_exc;
    logic        n_bd;
    next_PC = np; stall = st; req = rq; D_eret = er; D_is_jump = jp;
    n_f = m_f_pc; n_dpc = m_d_pc; n_di = m_d_instr; n_exc = m_d_exc; n_bd = m_d_bd;
    if (rq) begin
      n_f = np; n_dpc = 32'h0000_4180; n_di = 32'h0; n_exc = 5'd0; n_bd = 1'b0;
    end else if (st) begin
      n_f = m_f_pc;
    end else if (er) begin
      n_f = np; n_dpc = m_f_pc; n_di = 32'h0; n_exc = 5'd0; n_bd = 1'b0;
    end else begin
      n_f = np; n_dpc = m_f_pc; n_bd = jp;
      n_di  = fetch_fault(m_f_pc) ? 32'h0 : im_word(m_f_pc);
      n_exc = fetch_fault(m_f_pc) ? 5'd4 : 5'd0;
    end
    @(posedge clk);
    #2;
    m_f_pc = n_f; m_d_pc = n_dpc; m_d_instr = n_di; m_d_exc = n_exc; m_d_bd = n_bd;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("F_PC", F_PC, m_f_pc);
      chk("D_PC", D_PC, m_d_pc);
      chk("D_Instr", D_Instr, m_d_instr);
      chk("D_ExcCode", {27'd0, D_ExcCode}, {27'd0, m_d_exc});
      chk("D_BD", {31'd0, D_BD}, {31'd0, m_d_bd});
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_F_PC"}, F_PC, 32'h0000_3000);
    chk({tag, "_D_PC"}, D_PC, 32'h0000_3000);
    chk({tag, "_D_Instr"}, D_Instr, 32'h0000_0000);
    chk({tag, "_D_ExcCode"}, {27'd0, D_ExcCode}, 32'h0);
    chk({tag, "_D_BD"}, {31'd0, D_BD}, 32'h0);
  endtask

  initial begin
    logic [31:0] np;
    int r;
    rst_n = 1'b1;
    next_PC = 32'h0; stall = 1'b0; req = 1'b0; D_eret = 1'b0; D_is_jump = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Sequential fetch
    for (int i = 0; i < 3; i++) tick(m_f_pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_F_PC", F_PC, 32'h0000_300C);
    chk("seq_D_PC", D_PC, 32'h0000_3008);
    chk("seq_D_Instr", D_Instr, im_word(32'h0000_3008));

    // Stall holds everything at F_PC=0x3010
    tick(32'h0000_3010, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_5550, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(32'h0000_6660, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_F_PC", F_PC, 32'h0000_3010);
    chk("stall_D_PC", D_PC, 32'h0000_300C);
    tick(32'h0000_3014, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume_F_PC", F_PC, 32'h0000_3014);

    // Exception request overrides stall
    tick(32'h0000_4180, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("req_F_PC", F_PC, 32'h0000_4180);
    chk("req_D_PC", D_PC, 32'h0000_4180);
    chk("req_D_Instr", D_Instr, 32'h0);
    chk("req_D_BD", {31'd0, D_BD}, 32'h0);

    // Delay slot flag, then eret flush
    tick(32'h0000_3020, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_3024, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bd_D_PC", D_PC, 32'h0000_3020);
    chk("bd_D_BD", {31'd0, D_BD}, 32'h1);
    tick(32'h0000_3104, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("eret_D_Instr", D_Instr, 32'h0);
    chk("eret_F_PC", F_PC, 32'h0000_3104);
    chk("eret_D_PC", D_PC, 32'h0000_3024);

    // Misaligned and out-of-range fetches
    tick(32'h0000_3002, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_3008, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_ADEL_EN
    chk("unal_exc", {27'd0, D_ExcCode}, 32'd4);
    chk("unal_instr", D_Instr, 32'h0);
`else
    chk("unal_exc", {27'd0, D_ExcCode}, 32'd0);
    chk("unal_instr", D_Instr, im_word(32'h0000_3002));
`endif
    tick(32'h0000_7000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_ADEL_EN
    chk("range_exc", {27'd0, D_ExcCode}, 32'd4);
`else
    chk("range_exc", {27'd0, D_ExcCode}, 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 80) np = (m_f_pc + 32'd4 > 32'h0000_6FFC) ? 32'h0000_3000 : m_f_pc + 32'd4;
      else if (r < 88) np = {$urandom_range(32'h0000_2F00, 32'h0000_7100)} & 32'hFFFF_FFFC;
      else if (r < 94) np = $urandom_range(32'h0000_3000, 32'h0000_6FFF);
      else np = $urandom;
      tick(np, $urandom_range(99) < 20, $urandom_range(99) < 5,
           $urandom_range(99) < 6, $urandom_range(99) < 25);
    end

    // Asynchronous reset mid-stall with req pending
    tick(32'h0000_3400, 1'b0, 1'b0, 1'b0, 1'b1);
    stall = 1'b1; req = 1'b1; next_PC = 32'h0000_4180;
    rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(m_f_pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_F_PC", F_PC, 32'h0000_300C);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f_pc_fd_reg.md
Name: f_pc_fd_reg

Overview:
- Fetch-stage program counter register plus the F/D pipeline register of the 5-stage MIPS core.
- Consumes next_PC from the D-stage next-PC selector. Produces F_PC, which drives the IM address and feeds back to that selector.
- Latches the fetched instruction and its PC, fetch exception code and delay-slot flag into D.
- Applies hazard-unit stalls, exception/interrupt flushes (req) and eret flushes.

Parameters:
RESET_PC, 32'h0000_3000, F_PC value after reset
HANDLER_PC, 32'h0000_4180, PC carried by a flushed bubble on req
IMEM_BASE, 32'h0000_3000, lowest legal fetch address
IMEM_TOP, 32'h0000_6FFC, highest legal fetch address

Ports:
clk  in  1  single clock, all state rising-edge
rst_n  in  1  asynchronous active-low reset
next_PC  in  32  next fetch address from D-stage next-PC selector
stall  in  1  hazard-unit stall; holds PC and F/D
req  in  1  exception/interrupt taken this cycle (from CP0)
D_eret  in  1  eret currently in D
D_is_jump  in  1  instruction currently in D is a branch/jump (next F instr is delay slot)
F_Instr_in  in  32  instruction word from IM at F_PC
F_PC  out  32  current fetch address
D_PC  out  32  PC of instruction in D
D_Instr  out  32  instruction in D
D_ExcCode  out  5  fetch exception code carried into D (0 = none, 4 = AdEL)
D_BD  out  1  instruction in D is in a branch delay slot

Behaviour:
- Reset (rst_n low, async): F_PC=RESET_PC, D_PC=RESET_PC, D_Instr=0, D_ExcCode=0, D_BD=0.
- Priority per edge, both registers: req > stall > D_eret > normal.
- req=1:
  - F_PC <= next_PC; the selector already drives HANDLER_PC.
  - F/D becomes a bubble: D_Instr=0, D_ExcCode=0, D_BD=0, D_PC=HANDLER_PC.
  - stall is ignored.
- stall=1, req=0: F_PC and all D_* hold their values.
- D_eret=1, stall=0, req=0:
  - F_PC <= next_PC (EPC+4 from the selector).
  - F/D bubble: D_Instr=0, D_ExcCode=0, D_BD=0, D_PC=F_PC. The eret delay slot is never executed.
- Normal:
  - F_PC <= next_PC.
  - D_PC <= F_PC.
  - D_Instr <= F_Instr_in, or 0 if a fetch exception is detected.
  - D_ExcCode <= fetch exception code.
  - D_BD <= D_is_jump.
- Fetch exception (comb on F_PC): AdEL (5'd4) when F_PC[1:0]!=0 or F_PC<IMEM_BASE or F_PC>IMEM_TOP. Comparisons are unsigned 32-bit.
- Latency: an instruction reaches D one cycle after its PC appears on F_PC. F_PC follows next_PC with one cycle of latency.
- No wrap-around handling: F_PC takes whatever next_PC supplies. Overflow past 32'hFFFF_FFFC is caught only by the range check.
- Reset asserted mid-operation: immediate return to reset values regardless of stall/req. The first edge after deassertion behaves as normal.
- D_BD is latched with the instruction. It is held under stall and cleared on any flush.

Optional Feature:
FETCH_ADEL_EN
- Defined: AdEL detection as above. The faulting instruction is replaced with 0 and D_ExcCode=4.
- Undefined: no range/alignment check. D_ExcCode is always 0 and D_Instr = F_Instr_in. The IMEM_BASE/IMEM_TOP parameters are unused.

Decomposition:
- Shared package (macro.v): ExcCode constants (EXC_NONE=0, EXC_ADEL=4), RESET_PC and HANDLER_PC default constants.
- One natural sub-module: f_adel_check, the combinational alignment/range checker, instantiated only under FETCH_ADEL_EN.
- PC register and F/D register stay in this module.

Test Plan:
- Reset then release: F_PC=0x3000; drive next_PC=F_PC+4 for 3 edges -> F_PC=0x300C, D_PC=0x3008, D_Instr = IM word at 0x3008.
- stall=1 for 2 cycles with F_PC=0x3010 -> F_PC, D_PC and D_Instr unchanged for both cycles; release -> advance resumes at 0x3014.
- req=1 with stall=1, next_PC=0x4180 -> F_PC=0x4180, D_Instr=0, D_PC=0x4180, D_BD=0.
- D_is_jump=1 while F holds 0x3020 -> next edge D_PC=0x3020, D_BD=1; D_eret=1 with next_PC=0x3104 -> D_Instr=0, F_PC=0x3104.
- FETCH_ADEL_EN: next_PC=0x3002 -> following edge D_ExcCode=4, D_Instr=0; next_PC=0x7000 -> D_ExcCode=4. Without the macro the same stimulus gives D_ExcCode=0.
- rst_n pulsed low mid-stall with req=1 -> all outputs return to reset values immediately, without waiting for a clock edge.
